// File: rtl/downsampling_pkg.sv
// Shared constants and matrix types for the 2x2 average-pooling stage.
package downsampling_pkg;
  localparam int WIDTH   = 8;
  localparam int IN_DIM  = 3;
  localparam int POOL    = 2;
  localparam int STRIDE  = 1;
  localparam int OUT_DIM = (IN_DIM - POOL) / STRIDE + 1;
  localparam int SUM_W   = WIDTH + 2;

  typedef logic [WIDTH-1:0]                    elem_t;
  typedef elem_t [IN_DIM-1:0][IN_DIM-1:0]      in_mat_t;
  typedef elem_t [OUT_DIM-1:0][OUT_DIM-1:0]    out_mat_t;
endpackage

// File: rtl/pool_window_avg.sv
// Combinational average of one 2x2 window. DOWNSAMPLING_ROUND_EN selects
// round-half-up; otherwise the result is the truncating floor.
module pool_window_avg #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] avg
);
  localparam int SW = WIDTH + 2;

  logic [SW-1:0] sum;
  logic [SW-1:0] sum_adj;

  assign sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};

`ifdef DOWNSAMPLING_ROUND_EN
  // Max (4*(2^W-1)+2) still fits in W+2 bits, so no saturation.
  assign sum_adj = sum + SW'(2);
`else
  assign sum_adj = sum;
`endif

  assign avg = sum_adj[SW-1:2];
endmodule

// File: rtl/downsampling.sv
// 3x3 -> 2x2 overlapping average pool, one registered result per accepted input.
// Optional build macro: DOWNSAMPLING_ROUND_EN (round half up instead of floor).
import downsampling_pkg::*;

module downsampling #(
  parameter int WIDTH  = downsampling_pkg::WIDTH,
  parameter int IN_DIM = downsampling_pkg::IN_DIM,
  parameter int POOL   = downsampling_pkg::POOL,
  parameter int STRIDE = downsampling_pkg::STRIDE,
  localparam int OUT_DIM = (IN_DIM - POOL) / STRIDE + 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [IN_DIM-1:0][IN_DIM-1:0][WIDTH-1:0]    conv_out,
  output logic                                        out_valid,
  output logic [OUT_DIM-1:0][OUT_DIM-1:0][WIDTH-1:0]  downsampled_out
);
  localparam int STAGES = 1;

  // The divide is a fixed 2-bit shift, so only 2x2 windows are meaningful.
  if (POOL != 2) begin : g_bad_pool
    $error("downsampling: POOL must be 2");
  end

  logic [OUT_DIM-1:0][OUT_DIM-1:0][WIDTH-1:0] avg_w;
  logic [STAGES:0]                            vld_pipe;

  for (genvar i = 0; i < OUT_DIM; i++) begin : g_row
    for (genvar j = 0; j < OUT_DIM; j++) begin : g_col
      pool_window_avg #(.WIDTH(WIDTH)) u_win (
        .a   (conv_out[i*STRIDE  ][j*STRIDE  ]),
        .b   (conv_out[i*STRIDE  ][j*STRIDE+1]),
        .c   (conv_out[i*STRIDE+1][j*STRIDE  ]),
        .d   (conv_out[i*STRIDE+1][j*STRIDE+1]),
        .avg (avg_w[i][j])
      );
    end
  end

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      downsampled_out    <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      // Load only on accepted inputs so idle-cycle garbage never reaches the output.
      if (in_valid) downsampled_out <= avg_w;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_downsampling.sv
// Randomized and directed bench for downsampling against a behavioural pooling model.
module tb_downsampling;
  import downsampling_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid;
  in_mat_t  conv_out;
  logic     out_valid;
  out_mat_t downsampled_out;

  int       errs   = 0;
  int       checks = 0;
  out_mat_t exp_out;
  logic     exp_vld;

  always #5 clk = ~clk;

  downsampling dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .conv_out        (conv_out),
    .out_valid       (out_valid),
    .downsampled_out (downsampled_out)
  );

  function automatic out_mat_t pool_ref(in_mat_t m);
    out_mat_t o;
    int s;
    for (int i = 0; i < OUT_DIM; i++)
      for (int j = 0; j < OUT_DIM; j++) begin
        s = 0;
        for (int r = 0; r < POOL; r++)
          for (int c = 0; c < POOL; c++)
            s += int'(m[i*STRIDE+r][j*STRIDE+c]);
`ifdef DOWNSAMPLING_ROUND_EN
        s = (s + 2) / 4;
`else
        s = s / 4;
`endif
        o[i][j] = elem_t'(s);
      end
    return o;
  endfunction

  function automatic in_mat_t fill(int v);
    in_mat_t m;
    for (int r = 0; r < IN_DIM; r++)
      for (int c = 0; c < IN_DIM; c++) m[r][c] = elem_t'(v);
    return m;
  endfunction

  function automatic out_mat_t ofill(int v);
    out_mat_t o;
    for (int r = 0; r < OUT_DIM; r++)
      for (int c = 0; c < OUT_DIM; c++) o[r][c] = elem_t'(v);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model by the same edge, compare both outputs.
  task automatic cycle(input in_mat_t m, input logic v, input logic r, input string tag);
    conv_out = m;
    in_valid = v;
    rst      = r;
    @(posedge clk);
    #1;
    if (r) begin
      exp_out = '0;
      exp_vld = 1'b0;
    end else if (v) begin
      exp_out = pool_ref(m);
      exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    chk({tag, "_vld"}, 64'(out_valid), 64'(exp_vld));
    chk({tag, "_out"}, 64'(downsampled_out), 64'(exp_out));
  endtask

  initial begin
    in_mat_t  m;
    in_mat_t  xm;
    out_mat_t e;
    logic     v, r;

    exp_out = '0;
    exp_vld = 1'b0;
    xm      = 'x;

    cycle(fill(0), 1'b0, 1'b1, "rst0");
    cycle(fill(5), 1'b1, 1'b1, "rst1");
    chk("rst_zero", 64'(downsampled_out), 64'(0));

    // Reference matrix.
    m[0][0] = 8'd0; m[0][1] = 8'd1; m[0][2] = 8'd2;
    m[1][0] = 8'd3; m[1][1] = 8'd0; m[1][2] = 8'd1;
    m[2][0] = 8'd2; m[2][1] = 8'd3; m[2][2] = 8'd0;
    cycle(m, 1'b1, 1'b0, "ref");
    e[0][0] = 8'd1; e[0][1] = 8'd1; e[1][0] = 8'd2; e[1][1] = 8'd1;
    chk("ref_const", 64'(downsampled_out), 64'(e));
    cycle(fill(0), 1'b0, 1'b0, "ref_hold");
    chk("ref_hold_const", 64'(downsampled_out), 64'(e));

    // Full scale.
    cycle(fill(255), 1'b1, 1'b0, "full");
    chk("full_const", 64'(downsampled_out), 64'(ofill(255)));

    // Rounding split: window sum 6.
    m = fill(0);
    m[0][0] = 8'd1; m[0][1] = 8'd2; m[1][0] = 8'd1; m[1][1] = 8'd2;
    cycle(m, 1'b1, 1'b0, "rnd");
`ifdef DOWNSAMPLING_ROUND_EN
    chk("rnd_00", 64'(downsampled_out[0][0]), 64'(2));
`else
    chk("rnd_00", 64'(downsampled_out[0][0]), 64'(1));
`endif

    // Back-to-back.
    cycle(fill(4), 1'b1, 1'b0, "b2b0");
    chk("b2b0_const", 64'(downsampled_out), 64'(ofill(4)));
    cycle(fill(8), 1'b1, 1'b0, "b2b1");
    chk("b2b1_const", 64'(downsampled_out), 64'(ofill(8)));
    cycle(fill(12), 1'b1, 1'b0, "b2b2");
    chk("b2b2_const", 64'(downsampled_out), 64'(ofill(12)));
    chk("b2b2_vld", 64'(out_valid), 64'(1));

    // Reset mid-operation, reset dominant over a concurrent valid.
    cycle(fill(9), 1'b1, 1'b0, "mid0");
    cycle(fill(9), 1'b1, 1'b1, "mid_rst");
    chk("mid_rst_vld", 64'(out_valid), 64'(0));
    chk("mid_rst_zero", 64'(downsampled_out), 64'(0));
    cycle(fill(9), 1'b0, 1'b0, "mid_post");
    chk("mid_post_vld", 64'(out_valid), 64'(0));
    chk("mid_post_zero", 64'(downsampled_out), 64'(0));
    cycle(fill(6), 1'b1, 1'b0, "mid6");
    chk("mid6_const", 64'(downsampled_out), 64'(ofill(6)));

    // Idle hold with undriven data.
    cycle(fill(7), 1'b1, 1'b0, "idle0");
    for (int k = 0; k < 5; k++) begin
      cycle(xm, 1'b0, 1'b0, "idle");
      chk("idle_const", 64'(downsampled_out), 64'(ofill(7)));
      chk("idle_vld0", 64'(out_valid), 64'(0));
    end

    // Random traffic with occasional resets.
    for (int k = 0; k < 300; k++) begin
      for (int rr = 0; rr < IN_DIM; rr++)
        for (int cc = 0; cc < IN_DIM; cc++) m[rr][cc] = elem_t'($urandom);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 24) == 0);
      cycle(v ? m : xm, v, r, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
